// File: rtl/alu_issue.sv
// alu_issue -- issue/writeback sequencer in front of the alu block.
// Accepts RV32I OP / OP-IMM words over valid/ready, decodes them onto the
// ALU operand/select inputs, writes the ALU result back into a 32x32
// register file and reports each retirement (or an illegal-drop pulse).
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   instr, instr_valid  instruction word and its valid
//   instr_ready         high in IDLE, low during EXEC and reset
//   alu_rs1/rs2         ALU operands (rs2 = register or immediate)
//   alu_funct3/funct7   ALU operation select / alt (SUB, SRA)
//   alu_rd, alu_z       ALU result and zero flag (combinational)
//   retire_*            one-cycle retire pulse with rd index, data, zero
//   err                 one-cycle pulse: illegal instruction dropped
module alu_issue #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     instr,
   input  logic            instr_valid,
   output logic            instr_ready,
   output logic [XLEN-1:0] alu_rs1,
   output logic [XLEN-1:0] alu_rs2,
   output logic [2:0]      alu_funct3,
   output logic            alu_funct7,
   input  logic [XLEN-1:0] alu_rd,
   input  logic            alu_z,
   output logic            retire_valid,
   output logic [4:0]      retire_rd,
   output logic [XLEN-1:0] retire_data,
   output logic            retire_z,
   output logic            err
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t          state_q;
   logic [31:0]     instr_q;
   logic [XLEN-1:0] rf_q [NREGS];
   logic            ready_q;
   logic            retire_valid_q, err_q, retire_z_q;
   logic [4:0]      retire_rd_q;
   logic [XLEN-1:0] retire_data_q;

   // Decode of the latched word; the ALU is driven from it continuously, so
   // outside EXEC it simply shows the last instruction.
   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic [4:0] rs1_idx, rs2_idx, rd_idx;
   logic       legal, alt;
   logic [XLEN-1:0] op_b;

   assign opc     = instr_q[6:0];
   assign rd_idx  = instr_q[11:7];
   assign f3      = instr_q[14:12];
   assign rs1_idx = instr_q[19:15];
   assign rs2_idx = instr_q[24:20];
   assign f7      = instr_q[31:25];

   always_comb begin
      legal = 1'b0;
      alt   = 1'b0;
      op_b  = '0;
      if (opc == OPC_OP) begin
         op_b  = rf_q[rs2_idx];
         alt   = instr_q[30];
         legal = (f7 == 7'd0) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
      end else if (opc == OPC_OP_IMM) begin
         if (f3 == 3'b001 || f3 == 3'b101) begin
            // Shifts: shamt only, bit30 selects SRA for 101.
            op_b  = {{(XLEN-5){1'b0}}, instr_q[24:20]};
            alt   = instr_q[30];
            legal = (f7 == 7'd0) || (f7 == F7_ALT && f3 == 3'b101);
         end else begin
            // Bit30 is just immediate data here, never an alt select.
            op_b  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
            legal = 1'b1;
         end
      end
   end

   // x0 is never written and is cleared on reset, so it always reads 0.
   assign alu_rs1    = rf_q[rs1_idx];
   assign alu_rs2    = op_b;
   assign alu_funct3 = f3;
   assign alu_funct7 = alt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         instr_q        <= '0;
         ready_q        <= 1'b0;
         retire_valid_q <= 1'b0;
         err_q          <= 1'b0;
         retire_rd_q    <= '0;
         retire_data_q  <= '0;
         retire_z_q     <= 1'b0;
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         retire_valid_q <= 1'b0;
         err_q          <= 1'b0;
         case (state_q)
            IDLE: begin
               if (instr_valid && ready_q) begin
                  instr_q <= instr;
                  state_q <= EXEC;
                  ready_q <= 1'b0;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            EXEC: begin
               if (legal) begin
                  if (rd_idx != 5'd0) rf_q[rd_idx] <= alu_rd;
                  retire_valid_q <= 1'b1;
                  retire_rd_q    <= rd_idx;
                  retire_data_q  <= alu_rd;
                  retire_z_q     <= alu_z;
               end else begin
                  err_q <= 1'b1;
               end
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign instr_ready  = ready_q;
   assign retire_valid = retire_valid_q;
   assign retire_rd    = retire_rd_q;
   assign retire_data  = retire_data_q;
   assign retire_z     = retire_z_q;
   assign err          = err_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] alu_rs1, alu_rs2, alu_rd;
   logic [2:0]  alu_funct3;
   logic        alu_funct7, alu_z;
   logic        retire_valid, retire_z, err;
   logic [4:0]  retire_rd;
   logic [31:0] retire_data;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] rf_m [32];

   always #5 clk = ~clk;

   alu_issue #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
      .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_rd(alu_rd),
      .alu_z(alu_z), .retire_valid(retire_valid), .retire_rd(retire_rd),
      .retire_data(retire_data), .retire_z(retire_z), .err(err)
   );

   // RV32I integer ALU semantics.
   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0: return alt ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return {31'd0, $signed(a) < $signed(b)};
         3'd3: return {31'd0, a < b};
         3'd4: return a ^ b;
         3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   // Stand-in for the alu block.
   assign alu_rd = alu_f(alu_rs1, alu_rs2, alu_funct3, alu_funct7);
   assign alu_z  = (alu_rd == 32'd0);

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference: what the instruction means architecturally.
   task automatic model(input logic [31:0] ins, output bit legal, output logic [31:0] a,
                        output logic [31:0] b, output logic [31:0] res, output bit alt);
      logic [6:0] op, f7;
      logic [2:0] f3;
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      a = rf_m[ins[19:15]]; b = 0; alt = 0; legal = 0;
      if (op == 7'h33) begin
         b = rf_m[ins[24:20]];
         alt = ins[30];
         legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      end else if (op == 7'h13) begin
         if (f3 == 1 || f3 == 5) begin
            b = {27'd0, ins[24:20]};
            alt = ins[30];
            legal = (f7 == 0) || (f7 == 7'h20 && f3 == 5);
         end else begin
            b = {{20{ins[31]}}, ins[31:20]};
            legal = 1;
         end
      end
      res = alu_f(a, b, f3, alt);
   endtask

   task automatic issue(input logic [31:0] ins);
      bit lg, al;
      logic [31:0] a, b, r;
      int w;
      @(negedge clk);
      w = 0;
      while (!instr_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      if (!instr_ready) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
      model(ins, lg, a, b, r, al);
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr = $urandom;  // must not matter after the accept edge
      chk("ready_exec", {31'd0, instr_ready}, 32'd0);
      chk("rv_exec", {31'd0, retire_valid}, 32'd0);
      chk("err_exec", {31'd0, err}, 32'd0);
      if (lg) begin
         chk("alu_rs1", alu_rs1, a);
         chk("alu_rs2", alu_rs2, b);
         chk("alu_funct3", {29'd0, alu_funct3}, {29'd0, ins[14:12]});
         chk("alu_funct7", {31'd0, alu_funct7}, {31'd0, al});
      end
      @(posedge clk); #1;
      chk("retire_valid", {31'd0, retire_valid}, {31'd0, lg});
      chk("err", {31'd0, err}, {31'd0, !lg});
      if (lg) begin
         chk("retire_rd", {27'd0, retire_rd}, {27'd0, ins[11:7]});
         chk("retire_data", retire_data, r);
         chk("retire_z", {31'd0, retire_z}, {31'd0, r == 0});
         if (ins[11:7] != 0) rf_m[ins[11:7]] = r;
      end
      chk("ready_idle", {31'd0, instr_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] ins;
      int sel;
      for (int i = 0; i < 32; i++) rf_m[i] = 0;
      rst_n = 1'b0; instr = 0; instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, instr_ready}, 32'd0);
      chk("rst_rv", {31'd0, retire_valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_rdata", retire_data, 32'd0);
      chk("rst_rs1", alu_rs1, 32'd0);
      chk("rst_rs2", alu_rs2, 32'd0);
      chk("rst_f", {28'd0, alu_funct3, alu_funct7}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);

      // Load and add, zero flag, immediates and shifts.
      issue(32'h01400093);
      issue(32'h01E00113);
      issue(32'h002081B3);
      chk("add50", retire_data, 32'd50);
      issue(32'h40108233);
      chk("sub_z", {31'd0, retire_z}, 32'd1);
      issue(32'hFF000293);
      issue(32'h4022D313);
      chk("srai_x6", retire_data, 32'hFFFFFFFC);
      // x0 and illegal instructions.
      issue(32'h00500013);
      chk("x0_data", retire_data, 32'd5);
      issue(32'h000003B3);
      issue(32'h0000007F);
      issue(32'h4020F233);
      issue(32'h0020E233);

      // Random mix, small register window for dependencies.
      for (int n = 0; n < 60; n++) begin
         ins = $urandom;
         sel = $urandom_range(0, 9);
         ins[11:10] = 2'b00; ins[19:18] = 2'b00;
         if (sel < 5) begin
            ins[6:0] = 7'h33;
            ins[24:23] = 2'b00;
         end else if (sel < 9) begin
            ins[6:0] = 7'h13;
         end
         if (sel < 9 && $urandom_range(0, 3) != 0)
            ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
         issue(ins);
      end

      // Reset in the middle of EXEC.
      issue(32'h01400093);
      @(negedge clk);
      instr = 32'h01400093; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", {31'd0, instr_ready}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("midrst_rv", {31'd0, retire_valid}, 32'd0);
         chk("midrst_err", {31'd0, err}, 32'd0);
         chk("midrst_ready", {31'd0, instr_ready}, 32'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) rf_m[i] = 0;
      @(posedge clk); #1;
      chk("midrst_ready_rel", {31'd0, instr_ready}, 32'd1);
      chk("midrst_rv_rel", {31'd0, retire_valid}, 32'd0);
      issue(32'h000083B3);
      chk("x1_cleared", retire_data, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
